// File: rtl/m_hart_arbiter_if.sv
// Bundle between the hart clusters and the shared-port arbiter: request/grant plus LR/SC/store events.
interface m_hart_arbiter_if #(
  parameter int NHARTS = 2,
  parameter int AW     = 32,
  parameter int HW     = 1
);
  logic [NHARTS-1:0]    w_req;
  logic                 w_busy;
  logic [NHARTS-1:0]    w_grant;
  logic [HW-1:0]        w_grant_id;
  logic                 w_gvalid;
  logic [NHARTS*AW-1:0] w_addr;
  logic [NHARTS-1:0]    w_lr;
  logic [NHARTS-1:0]    w_sc;
  logic [NHARTS-1:0]    w_st;
  logic [NHARTS-1:0]    w_inval;
  logic [NHARTS-1:0]    w_sc_ok;
  logic [NHARTS-1:0]    w_resv;

  modport master (
    output w_req, w_busy, w_addr, w_lr, w_sc, w_st, w_inval,
    input  w_grant, w_grant_id, w_gvalid, w_sc_ok, w_resv
  );

  modport slave (
    input  w_req, w_busy, w_addr, w_lr, w_sc, w_st, w_inval,
    output w_grant, w_grant_id, w_gvalid, w_sc_ok, w_resv
  );
endinterface

// File: rtl/m_hart_arbiter.sv
// Round-robin arbiter for NHARTS harts onto one memory port plus the shared LR/SC reservation table.
// Grant registered one cycle after request; w_busy freezes the current grant; one idle cycle between tenures.
module m_hart_arbiter #(
  parameter int NHARTS = 2,
  parameter int AW     = 32,
  parameter int HW     = 1
) (
  input logic             CLK,
  input logic             RST,
  m_hart_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [NHARTS-1:0] grant, grant_nxt;
  logic [HW-1:0]     grant_id, grant_id_nxt;
  logic [HW-1:0]     last, last_nxt;
  logic [HW-1:0]     winner;
  logic [HW-1:0]     cand;
  logic              found;

  logic [NHARTS-1:0] resv_valid, resv_valid_nxt;
  logic [AW-3:0]     resv_addr     [NHARTS];
  logic [AW-3:0]     resv_addr_nxt [NHARTS];
  logic [AW-3:0]     word          [NHARTS];
  logic [NHARTS-1:0] sc_ok;

  // Scan starts just after the previous owner so every waiter is reached within NHARTS-1 tenures.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NHARTS; i++) begin
      cand = HW'((int'(last) + i) % NHARTS);
      if (!found && bus.w_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    last_nxt     = last;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt    = NHARTS'(1) << winner;
          grant_id_nxt = winner;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (!bus.w_req[grant_id] && !bus.w_busy) begin
          last_nxt  = grant_id;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      last     <= HW'(NHARTS - 1);
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      last     <= last_nxt;
    end
  end

  // Events only act for the granted hart; the grant is one-hot so at most one hart fires per cycle.
  always_comb begin
    resv_valid_nxt = resv_valid & ~bus.w_inval;
    for (int h = 0; h < NHARTS; h++) begin
      word[h]          = bus.w_addr[h*AW+2 +: AW-2];
      resv_addr_nxt[h] = resv_addr[h];
      sc_ok[h]         = grant[h] && bus.w_sc[h] && resv_valid[h] && (resv_addr[h] == word[h]);
    end
    for (int g = 0; g < NHARTS; g++) begin
      if (grant[g]) begin
        if (bus.w_sc[g]) begin
          resv_valid_nxt[g] = 1'b0;
          for (int k = 0; k < NHARTS; k++) begin
            if (sc_ok[g] && k != g && resv_valid[k] && resv_addr[k] == word[g])
              resv_valid_nxt[k] = 1'b0;
          end
        end else if (bus.w_lr[g]) begin
          resv_valid_nxt[g] = 1'b1;
          resv_addr_nxt[g]  = word[g];
        end else if (bus.w_st[g]) begin
          for (int k = 0; k < NHARTS; k++) begin
            if (resv_valid[k] && resv_addr[k] == word[g])
              resv_valid_nxt[k] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      resv_valid <= '0;
      for (int h = 0; h < NHARTS; h++) resv_addr[h] <= '0;
    end else begin
      resv_valid <= resv_valid_nxt;
      for (int h = 0; h < NHARTS; h++) resv_addr[h] <= resv_addr_nxt[h];
    end
  end

  assign bus.w_grant    = grant;
  assign bus.w_grant_id = grant_id;
  assign bus.w_gvalid   = |grant;
  assign bus.w_sc_ok    = sc_ok;
  assign bus.w_resv     = resv_valid;

endmodule

// File: tb/tb_m_hart_arbiter.sv
// Bench for m_hart_arbiter with 4 harts: directed scenarios plus random traffic against a behavioural model.
module tb_m_hart_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  m_hart_arbiter_if #(.NHARTS(N), .AW(32), .HW(2)) bus ();
  m_hart_arbiter #(.NHARTS(N), .AW(32), .HW(2)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model: owner is the granted hart or -1, reservations are plain arrays.
  int         m_owner;
  int         m_last;
  bit         m_init = 0;
  bit         m_rv [N];
  logic [29:0] m_ra [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] wa(input int h);
    return bus.w_addr[h*32+2 +: 30];
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] e_grant, e_resv, e_ok;
    bit nv [N];
    logic [29:0] na [N];
    logic [29:0] a;
    bit ok;
    if (m_init) begin
      e_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      for (int h = 0; h < N; h++) begin
        e_resv[h] = m_rv[h];
        e_ok[h]   = (m_owner == h) && bus.w_sc[h] && m_rv[h] && (m_ra[h] == wa(h));
      end
      chk("grant", 64'(bus.w_grant), 64'(e_grant));
      chk("gvalid", 64'(bus.w_gvalid), 64'(m_owner >= 0));
      if (m_owner >= 0) chk("grant_id", 64'(bus.w_grant_id), 64'(m_owner));
      chk("resv", 64'(bus.w_resv), 64'(e_resv));
      chk("sc_ok", 64'(bus.w_sc_ok), 64'(e_ok));
    end
    if (rst) begin
      m_init  = 1;
      m_owner = -1;
      m_last  = N - 1;
      for (int h = 0; h < N; h++) begin m_rv[h] = 0; m_ra[h] = '0; end
    end else if (m_init) begin
      for (int k = 0; k < N; k++) begin
        nv[k] = m_rv[k] && !bus.w_inval[k];
        na[k] = m_ra[k];
      end
      if (m_owner >= 0) begin
        a = wa(m_owner);
        if (bus.w_sc[m_owner]) begin
          ok = m_rv[m_owner] && m_ra[m_owner] == a;
          nv[m_owner] = 0;
          for (int k = 0; k < N; k++)
            if (ok && k != m_owner && m_rv[k] && m_ra[k] == a) nv[k] = 0;
        end else if (bus.w_lr[m_owner]) begin
          nv[m_owner] = 1;
          na[m_owner] = a;
        end else if (bus.w_st[m_owner]) begin
          for (int k = 0; k < N; k++)
            if (m_rv[k] && m_ra[k] == a) nv[k] = 0;
        end
      end
      for (int k = 0; k < N; k++) begin m_rv[k] = nv[k]; m_ra[k] = na[k]; end
      if (m_owner < 0) begin
        for (int i = 1; i <= N; i++) begin
          if (m_owner < 0 && bus.w_req[(m_last + i) % N]) m_owner = (m_last + i) % N;
        end
      end else if (!bus.w_req[m_owner] && !bus.w_busy) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int h, input logic [31:0] a);
    bus.w_addr[h*32 +: 32] = a;
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    rst = 1'b1;
    bus.w_req = 4'b0011; bus.w_busy = 1'b0; bus.w_addr = '0;
    bus.w_lr = '0; bus.w_sc = '0; bus.w_st = '0; bus.w_inval = '0;

    // Reset held with requests pending
    cyc(); cyc();
    chk("rst_grant", 64'(bus.w_grant), 64'h0);
    chk("rst_resv", 64'(bus.w_resv), 64'h0);
    rst = 1'b0;
    cyc();
    chk("first_grant", 64'(bus.w_grant), 64'h1);
    bus.w_req = '0;
    cyc();
    chk("release", 64'(bus.w_grant), 64'h0);

    // Round robin with all harts requesting
    rst = 1'b1;
    cyc();
    rst = 1'b0; bus.w_req = 4'hF;
    cyc();
    for (int n = 0; n < 4; n++) begin
      chk("rr_order", 64'(bus.w_grant), 64'(rr_exp[n]));
      cyc(); cyc();
      bus.w_req = 4'hF & ~rr_exp[n];
      cyc();
      chk("rr_gap", 64'(bus.w_grant), 64'h0);
      bus.w_req = 4'hF;
      cyc();
    end
    chk("rr_wrap", 64'(bus.w_grant), 64'(rr_exp[4]));

    // Busy freezes the grant after the owner lets go
    bus.w_busy = 1'b1; bus.w_req = '0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("freeze", 64'(bus.w_grant), 64'h1);
    end
    bus.w_busy = 1'b0;
    cyc();
    chk("unfreeze", 64'(bus.w_grant), 64'h0);

    // LR then SC to the same word
    bus.w_req = 4'b0001;
    cyc();
    chk("grant0", 64'(bus.w_grant), 64'h1);
    set_addr(0, 32'h8000_0010); bus.w_lr = 4'b0001;
    cyc();
    bus.w_lr = '0;
    chk("lr_resv", 64'(bus.w_resv), 64'h1);
    set_addr(0, 32'h8000_0013); bus.w_sc = 4'b0001;
    #1;
    chk("sc_ok", 64'(bus.w_sc_ok), 64'h1);
    cyc();
    bus.w_sc = '0;
    chk("sc_clear", 64'(bus.w_resv), 64'h0);

    // Store from another hart steals the reservation
    set_addr(0, 32'h100); bus.w_lr = 4'b0001;
    cyc();
    bus.w_lr = '0; bus.w_req = 4'b0010;
    cyc(); cyc();
    chk("grant1", 64'(bus.w_grant), 64'h2);
    set_addr(1, 32'h100); bus.w_st = 4'b0010;
    cyc();
    bus.w_st = '0;
    chk("steal", 64'(bus.w_resv), 64'h0);
    bus.w_req = 4'b0001;
    cyc(); cyc();
    chk("regrant0", 64'(bus.w_grant), 64'h1);
    set_addr(0, 32'h100); bus.w_sc = 4'b0001;
    #1;
    chk("sc_fail", 64'(bus.w_sc_ok), 64'h0);
    cyc();
    bus.w_sc = '0;

    // Gating and inval/LR priority
    set_addr(0, 32'h200); bus.w_lr = 4'b0001;
    cyc();
    bus.w_lr = '0;
    chk("lr2", 64'(bus.w_resv), 64'h1);
    set_addr(1, 32'h200); bus.w_sc = 4'b0010;
    #1;
    chk("ungated_sc", 64'(bus.w_sc_ok), 64'h0);
    cyc();
    bus.w_sc = '0;
    chk("no_change", 64'(bus.w_resv), 64'h1);
    set_addr(0, 32'h300); bus.w_lr = 4'b0001; bus.w_inval = 4'b0001;
    cyc();
    bus.w_lr = '0; bus.w_inval = '0;
    chk("lr_beats_inval", 64'(bus.w_resv), 64'h1);
    bus.w_inval = 4'b0001;
    cyc();
    bus.w_inval = '0;
    chk("inval", 64'(bus.w_resv), 64'h0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int h = 0; h < N; h++) begin
        if ($urandom_range(0, 5) == 0) bus.w_req[h] = ~bus.w_req[h];
        set_addr(h, 32'h100 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3)));
        bus.w_lr[h]    = ($urandom_range(0, 3) == 0);
        bus.w_sc[h]    = ($urandom_range(0, 3) == 0);
        bus.w_st[h]    = ($urandom_range(0, 7) == 0);
        bus.w_inval[h] = ($urandom_range(0, 15) == 0);
      end
      bus.w_busy = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 499) == 0);
    end
    cyc();
    rst = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
